adder_full_8bit_reg: RTL and testbench
======================================

Name: adder_full_8bit_reg

Overview:
- Registered 8-bit binary adder with carry-in and carry-out: proC:sum = add + aug + preC.
- The datapath is a ripple chain of eight 1-bit full-adder cells. The result is captured in an output register on the rising clock edge.
- Used as a leaf arithmetic element wherever a clocked 8-bit add with carry chaining is needed. proC of one stage feeds preC of the next stage for wider adds.

Parameters:
- none (width fixed at 8 bits)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- add  input  8  addend, unsigned (two's-complement when the overflow feature is used)
- aug  input  8  augend
- preC  input  1  carry-in
- in_valid  input  1  operands valid; capture the result this edge
- sum  output  8  registered sum bits [7:0]
- proC  output  1  registered carry-out (bit 8 of the result)
- out_valid  output  1  registered; high for one cycle per accepted operand set

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Combinational core:
  - c[0] = preC.
  - For i = 0..7: s[i] = add[i] ^ aug[i] ^ c[i]; c[i+1] = (add[i] & aug[i]) | (c[i] & (add[i] ^ aug[i])).
  - Result: {c[8], s[7:0]} equals the 9-bit value add + aug + preC exactly. No saturation; the 9-bit range 0..511 is never exceeded.
- Reset: on a clk rising edge with rst=1, sum=8'h00, proC=0, out_valid=0. rst takes precedence over in_valid on the same edge.
- Capture: on a rising edge with rst=0 and in_valid=1, load sum <= s and proC <= c[8]. Latency is 1 clock from operand presentation to result.
- out_valid <= in_valid every non-reset edge, so back-to-back in_valid gives one result per cycle with no bubbles.
- Hold: with in_valid=0, sum and proC keep their last values and out_valid drops to 0.
- Operands are sampled only at the capture edge. Changes between edges have no effect on outputs.
- Reset mid-stream: an operand set presented on the reset edge is discarded. The first result after reset appears one cycle after the first in_valid=1 with rst=0.
- Boundaries:
  - 8'hFF + 8'hFF + 1 gives proC=1, sum=8'hFF.
  - 8'h00 + 8'h00 + 0 gives proC=0, sum=8'h00.
- No X-propagation guard is required. Outputs are fully defined after the first reset edge.

Optional Feature:
- Macro: ADDER_FULL_8BIT_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, registered).
  - Two's-complement overflow: ovf = c[8] ^ c[7].
  - Captured and held exactly like sum; reset value 0.
- When undefined: the ovf port and its logic are absent, and all other behaviour is identical.

Test Plan:
- rst=1 for 2 edges, then rst=0 -> sum=8'h00, proC=0, out_valid=0.
- add=8'b00000000, aug=8'b00000000, preC=0, in_valid=1 -> next cycle sum=8'b00000000, proC=0, out_valid=1. Then preC=1 -> sum=8'b00000001, proC=0.
- add=8'b01010101, aug=8'b10101010, preC=1 -> sum=8'b00000000, proC=1 (full carry ripple through all 8 cells).
- Back-to-back in_valid over 3 cycles: 8'hFF+8'h01+0, 8'h80+8'h80+0, 8'hFF+8'hFF+1 -> results {1,00}, {1,00}, {1,FF} on consecutive cycles; then in_valid=0 -> values hold, out_valid=0.
- in_valid=1 with rst=1 on the same edge (add=8'h10, aug=8'h20) -> outputs stay 0, out_valid=0.
- With ADDER_FULL_8BIT_OVF_EN:
  - 8'h7F+8'h01+0 -> ovf=1, sum=8'h80, proC=0.
  - 8'hFF+8'h01+0 -> ovf=0, proC=1.

Source files
------------

// File: rtl/adder_full_8bit_reg.sv
// adder_full_8bit_reg -- registered 8-bit ripple-carry adder with carry-in/out.
//
// {proC, sum} = add + aug + preC. The result is registered one clock after
// in_valid, and out_valid marks it.
//
// Ports:
//   clk       in   system clock (rising edge)
//   rst       in   synchronous reset, active-high; has priority over in_valid
//   add       in   [7:0] addend
//   aug       in   [7:0] augend
//   preC      in   carry-in
//   in_valid  in   operands valid; result is captured on this edge
//   sum       out  [7:0] registered sum
//   proC      out  registered carry-out (result bit 8)
//   out_valid out  registered; one pulse per accepted operand set
//   ovf       out  registered two's-complement overflow
//                  (present only when ADDER_FULL_8BIT_OVF_EN is defined)
//
// Optional feature macro: ADDER_FULL_8BIT_OVF_EN

// One bit of the ripple chain.
module adder_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module adder_full_8bit_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] add,
  input  logic [7:0] aug,
  input  logic       preC,
  input  logic       in_valid,
  output logic [7:0] sum,
  output logic       proC,
`ifdef ADDER_FULL_8BIT_OVF_EN
  output logic       ovf,
`endif
  output logic       out_valid
);
  localparam int W = 8;

  // c[i] is the carry into cell i; c[W] is the carry-out.
  logic [W:0]   c;
  logic [W-1:0] s;

  assign c[0] = preC;

  adder_fa_cell u_fa [W-1:0] (
    .a  (add),
    .b  (aug),
    .ci (c[W-1:0]),
    .s  (s),
    .co (c[W:1])
  );

  // sum/proC only load on accepted operands; out_valid follows in_valid
  // every non-reset edge so back-to-back operands stream with no bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      proC      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        proC <= c[W];
      end
    end
  end

`ifdef ADDER_FULL_8BIT_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst)           ovf <= 1'b0;
    else if (in_valid) ovf <= c[W] ^ c[W-1];
  end
`endif

endmodule

// File: tb/tb_adder_full_8bit_reg.sv
module tb_adder_full_8bit_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] add, aug;
  logic       preC, in_valid;
  logic [7:0] sum;
  logic       proC, out_valid;
`ifdef ADDER_FULL_8BIT_OVF_EN
  logic       ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_full_8bit_reg dut (
    .clk       (clk),
    .rst       (rst),
    .add       (add),
    .aug       (aug),
    .preC      (preC),
    .in_valid  (in_valid),
    .sum       (sum),
    .proC      (proC),
`ifdef ADDER_FULL_8BIT_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] add;
    logic [7:0] aug;
    logic       preC;
    logic       iv;
    logic [7:0] e_sum;
    logic       e_c;
    logic       e_ov;
    logic       e_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] es, input logic ec,
                            input logic eov, input logic eovf);
    chk({name, ".sum"},       {24'd0, sum},       {24'd0, es});
    chk({name, ".proC"},      {31'd0, proC},      {31'd0, ec});
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
`ifdef ADDER_FULL_8BIT_OVF_EN
    chk({name, ".ovf"},       {31'd0, ovf},       {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("unexpected x in table");
`endif
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; add = '0; aug = '0; preC = 1'b0; in_valid = 1'b0;

    //          name        rst add    aug    pc iv   sum    c  ov ovf
    tbl.push_back('{"rst0",     1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{"rst1",     1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{"zero",     0, 8'h00, 8'h00, 0, 1, 8'h00, 0, 1, 0});
    tbl.push_back('{"cin",      0, 8'h00, 8'h00, 1, 1, 8'h01, 0, 1, 0});
    tbl.push_back('{"ripple",   0, 8'h55, 8'hAA, 1, 1, 8'h00, 1, 1, 0});
    tbl.push_back('{"b2b_0",    0, 8'hFF, 8'h01, 0, 1, 8'h00, 1, 1, 0});
    tbl.push_back('{"b2b_1",    0, 8'h80, 8'h80, 0, 1, 8'h00, 1, 1, 1});
    tbl.push_back('{"b2b_2",    0, 8'hFF, 8'hFF, 1, 1, 8'hFF, 1, 1, 0});
    tbl.push_back('{"hold0",    0, 8'h12, 8'h34, 1, 0, 8'hFF, 1, 0, 0});
    tbl.push_back('{"hold1",    0, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 0, 0});
    tbl.push_back('{"rst_iv",   1, 8'h10, 8'h20, 0, 1, 8'h00, 0, 0, 0});
    tbl.push_back('{"post_rst", 0, 8'h10, 8'h20, 0, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{"ovf_pos",  0, 8'h7F, 8'h01, 0, 1, 8'h80, 0, 1, 1});
    tbl.push_back('{"ovf_no",   0, 8'hFF, 8'h01, 0, 1, 8'h00, 1, 1, 0});
    tbl.push_back('{"first",    0, 8'h10, 8'h20, 0, 1, 8'h30, 0, 1, 0});
    tbl.push_back('{"mid_rst",  1, 8'hAB, 8'hCD, 1, 1, 8'h00, 0, 0, 0});
    tbl.push_back('{"mid_hold", 0, 8'hAB, 8'hCD, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{"after",    0, 8'h3C, 8'h0F, 1, 1, 8'h4C, 0, 1, 0});

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; add = tbl[i].add; aug = tbl[i].aug;
      preC = tbl[i].preC; in_valid = tbl[i].iv;
      @(posedge clk); #1;
      check_outs(tbl[i].name, tbl[i].e_sum, tbl[i].e_c, tbl[i].e_ov, tbl[i].e_ovf);
    end

    // Operands wiggling between edges must not disturb the registered result.
    @(negedge clk);
    rst = 1'b0; add = 8'hA3; aug = 8'h01; preC = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    check_outs("cap", 8'hA4, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    add = 8'hFF; aug = 8'hFF; preC = 1'b1;
    #2;
    add = 8'h00; aug = 8'h7F;
    @(negedge clk);
    check_outs("between", 8'hA4, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_outs("idle", 8'hA4, 1'b0, 1'b0, 1'b0);

    // Only the value present at the edge is taken.
    @(negedge clk);
    add = 8'h01; aug = 8'h01; preC = 1'b0; in_valid = 1'b1;
    #3;
    add = 8'hC0; aug = 8'h50; preC = 1'b1;
    @(posedge clk); #1;
    check_outs("late_chg", 8'h11, 1'b1, 1'b1, 1'b0);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_outs("final", 8'h11, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
